// File: rtl/rv_inst_decoder.sv
// Streaming RV32I instruction decoder: combinational field split and legality check,
// followed by a small output FIFO with backpressure and saturating statistics counters.
module rv_inst_decoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_type,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_raw,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_illegal,
  input  logic             clr_cnt
);

  // Handshake: a word transfers on in_valid && in_ready, an entry on out_valid && out_ready;
  // out_valid never waits on out_ready, and in_ready depends only on registered occupancy.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] TY_R   = 3'd0;
  localparam logic [2:0] TY_I   = 3'd1;
  localparam logic [2:0] TY_S   = 3'd2;
  localparam logic [2:0] TY_B   = 3'd3;
  localparam logic [2:0] TY_U   = 3'd4;
  localparam logic [2:0] TY_J   = 3'd5;
  localparam logic [2:0] TY_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]      typ;
    logic [6:0]      opc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] raw;
  } entry_t;

  entry_t     dec;
  logic       dec_illegal;
  logic [2:0] f3_w;
  logic [6:0] f7_w;
  logic       sgn;

  assign f3_w = in_inst[14:12];
  assign f7_w = in_inst[31:25];
  assign sgn  = in_inst[31];

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec.opc     = in_inst[6:0];
    dec.raw     = in_inst;
    unique case (in_inst[6:0])
      7'h33: begin
        dec.typ = TY_R;
        dec.rd  = in_inst[11:7];
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.f3  = f3_w;
        dec.f7  = f7_w;
        dec_illegal = !((f7_w == 7'h00) ||
                        (f7_w == 7'h20 && (f3_w == 3'b000 || f3_w == 3'b101)));
      end
      7'h13: begin
        dec.typ = TY_I;
        dec.rd  = in_inst[11:7];
        dec.rs1 = in_inst[19:15];
        dec.f3  = f3_w;
        dec.imm = {{(XLEN-12){sgn}}, in_inst[31:20]};
        // Shift-immediate forms reuse the upper immediate bits as a func7 field.
        dec_illegal = (f3_w == 3'b001 && f7_w != 7'h00) ||
                      (f3_w == 3'b101 && f7_w != 7'h00 && f7_w != 7'h20);
      end
      7'h23: begin
        dec.typ = TY_S;
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.f3  = f3_w;
        dec.imm = {{(XLEN-12){sgn}}, in_inst[31:25], in_inst[11:7]};
        dec_illegal = (f3_w > 3'b010);
      end
      7'h63: begin
        dec.typ = TY_B;
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.f3  = f3_w;
        dec.imm = {{(XLEN-13){sgn}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        dec_illegal = (f3_w == 3'b010 || f3_w == 3'b011);
      end
      7'h17: begin
        dec.typ = TY_U;
        dec.rd  = in_inst[11:7];
        dec.imm = {in_inst[31:12], 12'b0};
      end
      7'h6F: begin
        dec.typ = TY_J;
        dec.rd  = in_inst[11:7];
        dec.imm = {{(XLEN-21){sgn}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec     = '0;
      dec.typ = TY_ILL;
      dec.opc = in_inst[6:0];
      dec.raw = in_inst;
    end
  end

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q;
  logic            push, pop;
  logic [CNT_W-1:0] cnt_dec_q, cnt_ill_q;
  entry_t          head;

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CW'(DEPTH));
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_dec_q <= '0;
      cnt_ill_q <= '0;
    end else if (clr_cnt) begin
      cnt_dec_q <= '0;
      cnt_ill_q <= '0;
    end else if (push) begin
      if (!dec_illegal && cnt_dec_q != '1) cnt_dec_q <= cnt_dec_q + CNT_W'(1);
      if (dec_illegal && cnt_ill_q != '1)  cnt_ill_q <= cnt_ill_q + CNT_W'(1);
    end
  end

  assign cnt_decoded = cnt_dec_q;
  assign cnt_illegal = cnt_ill_q;

  assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_type   = head.typ;
  assign out_opcode = head.opc;
  assign out_rd     = head.rd;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_func3  = head.f3;
  assign out_func7  = head.f7;
  assign out_imm    = head.imm;
  assign out_raw    = head.raw;

endmodule

// File: tb/tb_rv_inst_decoder.sv
// Directed-vector bench for rv_inst_decoder; counters built 4 bits wide so saturation is reachable.
module tb_rv_inst_decoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_type;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_func3;
  logic [6:0]       out_func7;
  logic [31:0]      out_imm, out_raw;
  logic [CNT_W-1:0] cnt_decoded, cnt_illegal;
  logic             clr_cnt;

  int n_vec = 0;
  int n_err = 0;

  rv_inst_decoder #(.XLEN(32), .DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func3(out_func3),
    .out_func7(out_func7), .out_imm(out_imm), .out_raw(out_raw),
    .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal), .clr_cnt(clr_cnt)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] inst);
    int guard;
    in_valid = 1'b1;
    in_inst  = inst;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("push_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_entry(input string tag, input logic [2:0] typ, input logic [6:0] opc,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic [31:0] raw);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".type"},  {29'b0, out_type}, {29'b0, typ});
    chk({tag, ".opc"},   {25'b0, out_opcode}, {25'b0, opc});
    chk({tag, ".rd"},    {27'b0, out_rd}, {27'b0, rd});
    chk({tag, ".rs1"},   {27'b0, out_rs1}, {27'b0, rs1});
    chk({tag, ".rs2"},   {27'b0, out_rs2}, {27'b0, rs2});
    chk({tag, ".f3"},    {29'b0, out_func3}, {29'b0, f3});
    chk({tag, ".f7"},    {25'b0, out_func7}, {25'b0, f7});
    chk({tag, ".imm"},   out_imm, imm);
    chk({tag, ".raw"},   out_raw, raw);
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] dec, input logic [CNT_W-1:0] ill);
    chk({tag, ".cnt_dec"}, 32'(cnt_decoded), 32'(dec));
    chk({tag, ".cnt_ill"}, 32'(cnt_illegal), 32'(ill));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'b0, in_ready}, 32'd0);
    chk("rst.type",      {29'b0, out_type}, 32'd0);
    chk("rst.raw",       out_raw, 32'd0);
    chk_cnt("rst", 4'd0, 4'd0);
    rst_n = 1'b1;
    step();
    chk("rel.in_ready", {31'b0, in_ready}, 32'd1);

    // Legal classes, one at a time with a free-running consumer
    push_one(32'hFFF10093);
    chk_entry("addi", 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF10093);
    chk_cnt("addi", 4'd1, 4'd0);
    push_one(32'h402081B3);
    chk_entry("sub", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h402081B3);
    push_one(32'hFFDFF06F);
    chk_entry("jal", 3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDFF06F);
    push_one(32'h00000000);
    chk_entry("zero", 3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h00000000);
    push_one(32'h40009093);
    chk_entry("slli20", 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h40009093);
    chk_cnt("ill", 4'd3, 4'd2);
    push_one(32'h00112223);
    chk_entry("sw", 3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'h00, 32'h00000004, 32'h00112223);
    push_one(32'h00113223);
    chk_entry("s_f3_3", 3'd7, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h00113223);
    push_one(32'h00209463);
    chk_entry("bne", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h00000008, 32'h00209463);
    push_one(32'h12345297);
    chk_entry("auipc", 3'd4, 7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h12345297);
    push_one(32'h00000011);
    chk_entry("low2", 3'd7, 7'h11, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h00000011);
    chk_cnt("mix", 4'd6, 4'd4);

    // Saturation: 8 more legal words would reach 14 from 6 without the cap, so push 10
    for (int i = 0; i < 10; i++) push_one(32'hFFF10093);
    chk_cnt("sat", 4'd15, 4'd4);
    in_valid = 1'b1; in_inst = 32'hFFF10093; clr_cnt = 1'b1;
    step();
    in_valid = 1'b0; clr_cnt = 1'b0;
    chk_cnt("clr", 4'd0, 4'd0);
    step();
    chk("drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: two slots fill, third word waits, entries hold while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00112223;
    step();
    in_inst = 32'h00209463;
    step();
    in_inst = 32'h12345297;
    chk("full.in_ready", {31'b0, in_ready}, 32'd0);
    chk_entry("stall0", 3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'h00, 32'h00000004, 32'h00112223);
    step();
    step();
    chk("full2.in_ready", {31'b0, in_ready}, 32'd0);
    chk_entry("stall2", 3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'h00, 32'h00000004, 32'h00112223);
    out_ready = 1'b1;
    step();
    chk("free.in_ready", {31'b0, in_ready}, 32'd1);
    chk_entry("bp_b", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h00000008, 32'h00209463);
    step();
    in_valid = 1'b0;
    chk_entry("bp_c", 3'd4, 7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h12345297);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);
    chk_cnt("bp", 4'd3, 4'd0);

    // Asynchronous reset with a full buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h402081B3;
    step();
    step();
    in_valid = 1'b0;
    chk("prerst.in_ready", {31'b0, in_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst.raw", out_raw, 32'd0);
    chk_cnt("arst", 4'd0, 4'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arel.in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("arel.no_stale", {31'b0, out_valid}, 32'd0);
      step();
    end
    push_one(32'hFFDFF06F);
    chk_entry("after_rst", 3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDFF06F);
    chk_cnt("after_rst", 4'd1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_inst_decoder.md
Name: rv_inst_decoder

Overview:
- Streaming RISC-V RV32I instruction decoder for the verification environment; the inverse of the instruction-word packing format.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Splits each word into opcode class, register indices, func fields and sign-extended immediate, and flags illegal encodings.
- Buffered output stage with backpressure, plus saturating decode/illegal counters; feeds the reference model and scoreboard.

Parameters:
- XLEN, 32, instruction and immediate width
- DEPTH, 2, output buffer entries (power of two, >=2)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  decoder can accept a word
- in_inst  in  XLEN  raw instruction word
- out_valid  out  1  decoded entry valid
- out_ready  in  1  consumer accepts entry
- out_type  out  3  0=R,1=I,2=S,3=B,4=U,5=J,7=illegal
- out_opcode  out  7  inst[6:0]
- out_rd  out  5  inst[11:7]; 0 for S/B
- out_rs1  out  5  inst[19:15]; 0 for U/J
- out_rs2  out  5  inst[24:20]; 0 unless R/S/B
- out_func3  out  3  inst[14:12]; 0 for U/J
- out_func7  out  7  inst[31:25]; 0 unless R
- out_imm  out  XLEN  decoded immediate; 0 for R and illegal
- out_raw  out  XLEN  original word
- cnt_decoded  out  CNT_W  legal words accepted
- cnt_illegal  out  CNT_W  illegal words accepted
- clr_cnt  in  1  synchronous counter clear

Behaviour:
- Reset:
  - Buffer emptied; all out_* and counters 0.
  - in_ready=1 one cycle after rst_n deasserts.
  - Reset mid-transfer discards all buffered entries.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid=1, the entry and all out_* fields are held stable until the transfer.
- Pipeline and buffering:
  - Decode is combinational on in_inst; the result is written into the FIFO on the input transfer.
  - Latency: an accepted word appears on out_* the next cycle when the buffer was empty.
  - in_ready = !full, registered from occupancy. No combinational in→out ready path.
  - Simultaneous push and pop when full is not allowed (in_ready=0).
  - Simultaneous push and pop otherwise leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Opcode classes:
  - 0x33 R, 0x13 I, 0x23 S, 0x63 B, 0x17 U, 0x6F J.
  - Any other opcode is illegal, including inst[1:0]!=2'b11.
- Immediates (sign bit inst[31]):
  - I: sext(inst[31:20])
  - S: sext({inst[31:25],inst[11:7]})
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
  - U: {inst[31:12],12'b0}
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
- Illegal field checks:
  - R: func7 must be 0x00, or 0x20 with func3 in {000,101}.
  - I, func3=001: inst[31:25] must be 0x00.
  - I, func3=101: inst[31:25] must be in {0x00,0x20}.
  - B: func3 010 and 011 are illegal.
  - S: func3 must be <=010.
- Illegal output: out_type=7 with all fields zeroed except out_opcode and out_raw.
- Counters:
  - Increment on the input transfer, not on output.
  - Saturate at all-ones.
  - clr_cnt has priority over a same-cycle increment.

Test Plan:
- Empty decoder, out_ready=1, push 0xFFF10093 (ADDI x1,x2,-1) → next cycle out_valid=1, type=1, rd=1, rs1=2, func3=0, imm=0xFFFFFFFF; cnt_decoded=1.
- Push 0x402081B3 (SUB x3,x1,x2) → type=0, rd=3, rs1=1, rs2=2, func7=0x20, imm=0. Push 0xFFDFF06F (JAL x0,-4) → type=5, rd=0, imm=0xFFFFFFFC.
- Push 0x00000000 and 0x40009093 (SLLI with func7=0x20) → both type=7, imm=0; cnt_illegal=2, cnt_decoded unchanged.
- out_ready=0, push 3 words back-to-back → first two accepted, in_ready=0 on the third. Then raise out_ready → entries emerge in order, fields held stable while stalled, third word accepted once a slot frees.
- Preload cnt_decoded to 0xFFFF, push a legal word → stays 0xFFFF. Assert clr_cnt with a same-cycle push → counter reads 0.
- Buffer full, assert rst_n=0 asynchronously mid-cycle → out_valid drops immediately, counters 0. After release, in_ready=1 and a stale entry never appears.
